vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE0, 8'd25: item 0 price in cents.
REQ-002 Parameter PRICE1, 8'd40: item 1 price.
REQ-003 Parameter PRICE2, 8'd55: item 2 price.
REQ-004 Parameter PRICE3, 8'd75: item 3 price.
REQ-005 Parameter MAX_CREDIT, 8'd200: credit ceiling.
REQ-006 Parameter TIMEOUT_CYC, 16'd1000: idle cycles before auto-refund (used only under VEND_TIMEOUT_EN).
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 coin_valid  in  1  one-cycle coin strobe from the coin counter stage.
REQ-010 coin_type  in  2  00=5, 01=10, 10=25, 11=invalid.
REQ-011 sel_valid  in  1  one-cycle item selection strobe.
REQ-012 sel_item  in  2  selected item index.
REQ-013 cancel  in  1  one-cycle refund request.
REQ-014 disp_ready  in  1  dispenser accepts item when high.
REQ-015 credit  out  8  current accumulated credit.
REQ-016 disp_valid  out  1  item dispense request.
REQ-017 disp_item  out  2  item index, valid with disp_valid.
REQ-018 change_valid  out  1  one-cycle change/refund pulse.
REQ-019 change_amt  out  8  change value, valid with change_valid.
REQ-020 coin_reject  out  1  one-cycle pulse: coin returned.

Function
REQ-021 FSM SHALL have states IDLE (credit=0), ACCUM, VEND, CHANGE.
REQ-022 Valid coin (type 00/01/10) in IDLE/ACCUM: credit += value next cycle; FSM to ACCUM.
REQ-023 Coin with type 11, or credit+value > MAX_CREDIT: credit unchanged, coin_reject pulses next cycle.
REQ-024 Coins in VEND/CHANGE: rejected via coin_reject, credit unchanged.
REQ-025 sel_valid in ACCUM with credit >= PRICE[sel_item]: latch sel_item, enter VEND, assert disp_valid next cycle.
REQ-026 sel_valid with insufficient credit or in IDLE: ignored, no state change.
REQ-027 disp_valid/disp_item SHALL hold stable until cycle where disp_ready=1; that cycle completes the transfer.
REQ-028 On transfer: credit -= price; if remainder > 0 go CHANGE, else IDLE.
REQ-029 CHANGE: change_valid=1 and change_amt=credit for exactly one cycle; credit->0; next state IDLE.
REQ-030 cancel in ACCUM: enter CHANGE, refund full credit; cancel in IDLE/VEND/CHANGE ignored.
REQ-031 Same-cycle priority in ACCUM: cancel > sel_valid > coin_valid; lower-priority coin is rejected, other events dropped.
REQ-032 Exact price (credit==price): no change_valid pulse, return directly to IDLE.
REQ-033 Arithmetic 8-bit unsigned; no wrap possible given MAX_CREDIT <= 255.

Reset
REQ-034 rst low SHALL asynchronously force IDLE, credit=0, disp_valid=0, disp_item=0, change_valid=0, change_amt=0, coin_reject=0.
REQ-035 Reset during VEND SHALL abandon the dispense; no change pulse after release.
REQ-036 First state update occurs on first rising clk after rst goes high.

Configuration
REQ-037 Macro VEND_TIMEOUT_EN defined: 16-bit idle counter runs in ACCUM, cleared by any coin/sel/cancel strobe; at TIMEOUT_CYC cycles FSM enters CHANGE as if cancel.
REQ-038 Macro undefined: no counter logic, credit held indefinitely in ACCUM.

Verification
REQ-039 Reset low 50 ns, release, coins 25,25 -> credit=50; sel_item=1 with disp_ready=1 -> disp_valid one cycle, change_valid with change_amt=10, credit=0.
REQ-040 Coins 25,25,25, sel_item=3 -> disp_valid, no change_valid, state IDLE.
REQ-041 Coins 10,5, sel_item=0 -> ignored, credit stays 15; cancel -> change_amt=15.
REQ-042 disp_ready low 5 cycles in VEND -> disp_valid/disp_item stable, coin inserted meanwhile -> coin_reject pulse, credit unchanged.
REQ-043 coin_type=11 -> coin_reject, credit unchanged; credit 190 + coin 25 -> coin_reject, credit 190.
REQ-044 With VEND_TIMEOUT_EN, TIMEOUT_CYC=20: coin 10 then 20 idle cycles -> change_valid, change_amt=10; without macro, credit stays 10.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin accumulation, item vend with dispenser handshake, change/refund.
// Optional idle auto-refund in ACCUM is compiled in when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
  parameter logic [7:0]  PRICE0      = 8'd25,
  parameter logic [7:0]  PRICE1      = 8'd40,
  parameter logic [7:0]  PRICE2      = 8'd55,
  parameter logic [7:0]  PRICE3      = 8'd75,
  parameter logic [7:0]  MAX_CREDIT  = 8'd200,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       disp_ready,
  output logic [7:0] credit,
  output logic       disp_valid,
  output logic [1:0] disp_item,
  output logic       change_valid,
  output logic [7:0] change_amt,
  output logic       coin_reject,
  output logic [1:0] dbg_state
);

  // Dispense handshake: disp_valid/disp_item are held while in VEND and the
  // transfer completes on the first cycle disp_valid && disp_ready are both high.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

  state_t     r_state, w_next_state;
  logic [7:0] r_credit, w_next_credit;
  logic [1:0] r_disp_item, w_next_item;
  logic       r_coin_reject, w_next_reject;
  logic [7:0] w_coin_val, w_price_sel, w_price_disp, w_remain;
  logic [8:0] w_sum;
  logic       w_coin_ok, w_timeout;

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  always_comb begin
    w_coin_val = 8'd0;
    case (coin_type)
      2'b00:   w_coin_val = 8'd5;
      2'b01:   w_coin_val = 8'd10;
      2'b10:   w_coin_val = 8'd25;
      default: w_coin_val = 8'd0;
    endcase
  end

  assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_ok    = (coin_type != 2'b11) && (w_sum <= {1'b0, MAX_CREDIT});
  assign w_price_sel  = price_of(sel_item);
  assign w_price_disp = price_of(r_disp_item);
  assign w_remain     = r_credit - w_price_disp;

`ifdef VEND_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        w_strobe;

  assign w_strobe  = coin_valid | sel_valid | cancel;
  assign w_timeout = (r_state == ACCUM) && !w_strobe && (r_idle_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                             r_idle_cnt <= 16'd0;
    else if ((r_state == ACCUM) && !w_strobe && !w_timeout) r_idle_cnt <= r_idle_cnt + 16'd1;
    else                                                  r_idle_cnt <= 16'd0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next_state  = r_state;
    w_next_credit = r_credit;
    w_next_item   = r_disp_item;
    w_next_reject = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        // Within ACCUM: cancel beats a selection, which beats a coin.
        if ((r_state == ACCUM) && cancel) begin
          w_next_state  = CHANGE;
          w_next_reject = coin_valid;
        end else if ((r_state == ACCUM) && sel_valid && (r_credit >= w_price_sel)) begin
          w_next_state  = VEND;
          w_next_item   = sel_item;
          w_next_reject = coin_valid;
        end else if (w_timeout) begin
          w_next_state = CHANGE;
        end else if (coin_valid) begin
          if (w_coin_ok) begin
            w_next_credit = w_sum[7:0];
            w_next_state  = ACCUM;
          end else begin
            w_next_reject = 1'b1;
          end
        end
      end
      VEND: begin
        w_next_reject = coin_valid;
        if (disp_ready) begin
          w_next_credit = w_remain;
          w_next_state  = (w_remain != 8'd0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        w_next_reject = coin_valid;
        w_next_credit = 8'd0;
        w_next_state  = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_credit      <= 8'd0;
      r_disp_item   <= 2'd0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_credit      <= w_next_credit;
      r_disp_item   <= w_next_item;
      r_coin_reject <= w_next_reject;
    end
  end

  assign credit       = r_credit;
  assign disp_valid   = (r_state == VEND);
  assign disp_item    = r_disp_item;
  assign change_valid = (r_state == CHANGE);
  assign change_amt   = (r_state == CHANGE) ? r_credit : 8'd0;
  assign coin_reject  = r_coin_reject;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Define VEND_TIMEOUT_EN for both files to exercise the auto-refund build (TIMEOUT_CYC = 20 here).
module tb_vend_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, disp_ready = 1'b0;
  logic [1:0] coin_type = 2'd0, sel_item = 2'd0;
  logic [7:0] credit, change_amt;
  logic       disp_valid, change_valid, coin_reject;
  logic [1:0] disp_item, dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  int prices [4] = '{25, 40, 55, 75};
  int coinv  [4] = '{5, 10, 25, 0};

  // Model: credit balance, whether an item is waiting at the dispenser,
  // whether a change payout is showing this cycle, and the idle-cycle tally.
  int m_credit, m_item, m_idle;
  bit m_vend, m_change, m_rej;

  vend_ctrl #(.TIMEOUT_CYC(16'(TO))) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .disp_ready(disp_ready),
    .credit(credit), .disp_valid(disp_valid), .disp_item(disp_item),
    .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_credit = 0; m_item = 0; m_idle = 0;
    m_vend = 0; m_change = 0; m_rej = 0;
  endtask

  task automatic model_update(input bit cv, input int ct, input bit sv, input int si,
                              input bit cn, input bit dr);
    int nc = m_credit, ni = m_item, nidle = 0;
    bit nv = m_vend, nch = 0, nr = 0;
    bit accum = (m_credit > 0) && !m_vend && !m_change;
    if (m_change) begin
      nc = 0; nr = cv;
    end else if (m_vend) begin
      nr = cv;
      if (dr) begin
        nc = m_credit - prices[m_item]; nv = 0; nch = (nc > 0);
      end
    end else if (accum && cn) begin
      nch = 1; nr = cv;
    end else if (accum && sv && m_credit >= prices[si]) begin
      nv = 1; ni = si; nr = cv;
    end else if (cv) begin
      if (ct == 3 || m_credit + coinv[ct] > 200) nr = 1;
      else nc = m_credit + coinv[ct];
    end
`ifdef VEND_TIMEOUT_EN
    if (accum && !cv && !sv && !cn) begin
      if (m_idle == TO - 1) nch = 1;
      else nidle = m_idle + 1;
    end
`endif
    m_credit = nc; m_item = ni; m_vend = nv; m_change = nch; m_rej = nr; m_idle = nidle;
  endtask

  // Called at posedge+1; leaves time at the next posedge+1 with strobes cleared.
  task automatic step(input bit cv, input int ct, input bit sv, input int si,
                      input bit cn, input bit dr);
    coin_valid = cv; coin_type = 2'(ct); sel_valid = sv; sel_item = 2'(si);
    cancel = cn; disp_ready = dr;
    model_update(cv, ct, sv, si, cn, dr);
    @(posedge clk); #1;
    coin_valid = 0; sel_valid = 0; cancel = 0;
  endtask

  task automatic idle(input bit dr);
    step(0, 0, 0, 0, 0, dr);
  endtask

  task automatic test_reset();
    #20;
    n_cmp++;
    if ({credit, disp_valid, disp_item, change_valid, change_amt, coin_reject, dbg_state} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_values: got credit=%0d dv=%b di=%0d cv=%b ca=%0d rej=%b st=%0d, need all 0",
               credit, disp_valid, disp_item, change_valid, change_amt, coin_reject, dbg_state);
    end
    #30 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({credit, dbg_state} !== {8'd0, 2'd0}) begin
      n_bad++; $display("FAIL after_release: got credit=%0d st=%0d, need 0/0", credit, dbg_state);
    end
  endtask

  task automatic test_vend_change();
    step(1, 2, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 1);
    n_cmp++;
    if ({credit, dbg_state} !== {8'd50, 2'd1}) begin
      n_bad++; $display("FAIL two_coins: got credit=%0d st=%0d, need 50/1", credit, dbg_state);
    end
    step(0, 0, 1, 1, 0, 1);
    n_cmp++;
    if ({disp_valid, disp_item, change_valid} !== {1'b1, 2'd1, 1'b0}) begin
      n_bad++; $display("FAIL vend_start: got dv=%b di=%0d cv=%b, need 1/1/0", disp_valid, disp_item, change_valid);
    end
    idle(1);
    n_cmp++;
    if ({disp_valid, change_valid, change_amt} !== {1'b0, 1'b1, 8'd10}) begin
      n_bad++; $display("FAIL change_10: got dv=%b cv=%b amt=%0d, need 0/1/10", disp_valid, change_valid, change_amt);
    end
    idle(1);
    n_cmp++;
    if ({credit, change_valid, dbg_state} !== {8'd0, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL after_change: got credit=%0d cv=%b st=%0d, need 0/0/0", credit, change_valid, dbg_state);
    end
  endtask

  task automatic test_exact_price();
    repeat (3) step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 3, 0, 1);
    n_cmp++;
    if ({disp_valid, disp_item} !== {1'b1, 2'd3}) begin
      n_bad++; $display("FAIL exact_vend: got dv=%b di=%0d, need 1/3", disp_valid, disp_item);
    end
    idle(1);
    n_cmp++;
    if ({credit, change_valid, disp_valid, dbg_state} !== {8'd0, 1'b0, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL exact_done: got credit=%0d cv=%b dv=%b st=%0d, need 0/0/0/0",
                        credit, change_valid, disp_valid, dbg_state);
    end
  endtask

  task automatic test_insufficient_cancel();
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    n_cmp++;
    if ({credit, disp_valid, dbg_state} !== {8'd15, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL sel_ignored: got credit=%0d dv=%b st=%0d, need 15/0/1", credit, disp_valid, dbg_state);
    end
    step(0, 0, 0, 0, 1, 1);
    n_cmp++;
    if ({change_valid, change_amt} !== {1'b1, 8'd15}) begin
      n_bad++; $display("FAIL refund_15: got cv=%b amt=%0d, need 1/15", change_valid, change_amt);
    end
    idle(1);
  endtask

  task automatic test_stall();
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(i == 2, 2, 0, 0, 0, 0);
      n_cmp++;
      if ({disp_valid, disp_item, credit, coin_reject} !== {1'b1, 2'd1, 8'd50, 1'(i == 2)}) begin
        n_bad++; $display("FAIL stall_%0d: got dv=%b di=%0d credit=%0d rej=%b, need 1/1/50/%0d",
                          i, disp_valid, disp_item, credit, coin_reject, (i == 2));
      end
    end
    idle(1);
    n_cmp++;
    if ({change_valid, change_amt} !== {1'b1, 8'd10}) begin
      n_bad++; $display("FAIL stall_change: got cv=%b amt=%0d, need 1/10", change_valid, change_amt);
    end
    idle(1);
  endtask

  task automatic test_reject();
    step(1, 3, 0, 0, 0, 1);
    n_cmp++;
    if ({coin_reject, credit} !== {1'b1, 8'd0}) begin
      n_bad++; $display("FAIL bad_coin: got rej=%b credit=%0d, need 1/0", coin_reject, credit);
    end
    repeat (7) step(1, 2, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({credit, coin_reject} !== {8'd190, 1'b0}) begin
      n_bad++; $display("FAIL reach_190: got credit=%0d rej=%b, need 190/0", credit, coin_reject);
    end
    step(1, 2, 0, 0, 0, 1);
    n_cmp++;
    if ({credit, coin_reject} !== {8'd190, 1'b1}) begin
      n_bad++; $display("FAIL over_max: got credit=%0d rej=%b, need 190/1", credit, coin_reject);
    end
    step(1, 1, 0, 0, 0, 1);
    n_cmp++;
    if ({credit, coin_reject} !== {8'd200, 1'b0}) begin
      n_bad++; $display("FAIL at_max: got credit=%0d rej=%b, need 200/0", credit, coin_reject);
    end
    step(0, 0, 0, 0, 1, 1);
    idle(1);
  endtask

  task automatic test_priority();
    step(1, 2, 0, 0, 0, 1);
    step(1, 2, 0, 0, 1, 1);
    n_cmp++;
    if ({change_valid, change_amt, coin_reject} !== {1'b1, 8'd25, 1'b1}) begin
      n_bad++; $display("FAIL cancel_over_coin: got cv=%b amt=%0d rej=%b, need 1/25/1", change_valid, change_amt, coin_reject);
    end
    idle(1);
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 1, 1, 0, 0);
    n_cmp++;
    if ({disp_valid, credit, coin_reject} !== {1'b1, 8'd50, 1'b1}) begin
      n_bad++; $display("FAIL sel_over_coin: got dv=%b credit=%0d rej=%b, need 1/50/1", disp_valid, credit, coin_reject);
    end
    step(0, 0, 1, 0, 1, 0);
    n_cmp++;
    if ({disp_valid, disp_item, change_valid} !== {1'b1, 2'd1, 1'b0}) begin
      n_bad++; $display("FAIL vend_ignores: got dv=%b di=%0d cv=%b, need 1/1/0", disp_valid, disp_item, change_valid);
    end
    idle(1);
    idle(1);
  endtask

  task automatic test_reset_in_vend();
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({disp_valid, credit, change_valid, dbg_state} !== {1'b0, 8'd0, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL async_reset: got dv=%b credit=%0d cv=%b st=%0d, need 0/0/0/0",
                        disp_valid, credit, change_valid, dbg_state);
    end
    @(posedge clk); #1;
    disp_ready = 1'b1;
    rst = 1'b1;
    model_reset();
    idle(1);
    n_cmp++;
    if ({disp_valid, change_valid, credit, dbg_state} !== {1'b0, 1'b0, 8'd0, 2'd0}) begin
      n_bad++; $display("FAIL post_reset: got dv=%b cv=%b credit=%0d st=%0d, need 0/0/0/0",
                        disp_valid, change_valid, credit, dbg_state);
    end
  endtask

  task automatic test_timeout();
    step(1, 1, 0, 0, 0, 1);
`ifdef VEND_TIMEOUT_EN
    repeat (TO - 1) idle(1);
    n_cmp++;
    if ({credit, change_valid} !== {8'd10, 1'b0}) begin
      n_bad++; $display("FAIL before_timeout: got credit=%0d cv=%b, need 10/0", credit, change_valid);
    end
    idle(1);
    n_cmp++;
    if ({change_valid, change_amt} !== {1'b1, 8'd10}) begin
      n_bad++; $display("FAIL timeout_refund: got cv=%b amt=%0d, need 1/10", change_valid, change_amt);
    end
    idle(1);
`else
    repeat (TO + 5) idle(1);
    n_cmp++;
    if ({credit, change_valid, dbg_state} !== {8'd10, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL credit_held: got credit=%0d cv=%b st=%0d, need 10/0/1", credit, change_valid, dbg_state);
    end
    step(0, 0, 0, 0, 1, 1);
    idle(1);
`endif
  endtask

  task automatic test_random();
    logic [20:0] exp_v, act_v;
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      exp_v = {8'(m_credit), m_vend, 2'(m_item), m_change, (m_change ? 8'(m_credit) : 8'd0), m_rej};
      act_v = {credit, disp_valid, disp_item, change_valid, change_amt, coin_reject};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL random_%0d: got {credit,dv,di,cv,amt,rej}=%h, need %h", i, act_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_vend_change();
    test_exact_price();
    test_insufficient_cancel();
    test_stall();
    test_reject();
    test_priority();
    test_reset_in_vend();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
